// File: rtl/bfp_pkg.sv
// Shared types and elaboration helpers for the block-floating-point expander.
// Holds the FSM state type, the width helper and the parameter legality rule.
package bfp_pkg;

    typedef enum logic {
        HDR,
        DATA
    } state_e;

    function automatic int unsigned exp_width(input int unsigned m, input int unsigned n);
        return m + n;
    endfunction

    // The widening must be exact, so the output must hold mantissa * 2^EXP_MAX.
    function automatic bit params_ok(input int unsigned m_i, input int unsigned n_i,
                                     input int unsigned m_o, input int unsigned n_o,
                                     input int unsigned exp_w, input int unsigned exp_max,
                                     input int unsigned blk_len);
        return (m_i >= 1) && (m_o >= m_i + exp_max) && (n_o >= n_i) &&
               (exp_w >= 1) && (exp_w <= m_i + n_i) &&
               (exp_max < (32'd1 << exp_w)) && (blk_len >= 1);
    endfunction

endpackage

// File: rtl/bfp_shift.sv
// Combinational widening of one Q(M_I.N_I) mantissa to Q(M_O.N_O), scaled by 2^sh.
// Sign-extends, pads the fraction with zero LSBs, then barrel-shifts left.
module bfp_shift #(
    parameter int unsigned W_I   = 16,
    parameter int unsigned N_I   = 15,
    parameter int unsigned W_O   = 23,
    parameter int unsigned N_O   = 15,
    parameter int unsigned EXP_W = 4
) (
    input  logic [W_I-1:0]   mant,
    input  logic [EXP_W-1:0] sh,
    output logic [W_O-1:0]   res
);

    logic [W_O-1:0] ext;
    logic [W_O-1:0] padded;

    always_comb begin
        ext    = W_O'($signed(mant));
        padded = ext << (N_O - N_I);
        res    = padded << sh;
    end

endmodule

// File: rtl/bfp_expand.sv
// Block-floating-point expander: header beat carries the shared exponent,
// the following BLK_LEN beats are mantissas emitted as wide samples.
module bfp_expand
    import bfp_pkg::*;
#(
    parameter int unsigned M_I     = 1,
    parameter int unsigned N_I     = 15,
    parameter int unsigned M_O     = 8,
    parameter int unsigned N_O     = 15,
    parameter int unsigned EXP_W   = 4,
    parameter int unsigned EXP_MAX = 7,
    parameter int unsigned BLK_LEN = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [M_I+N_I-1:0]   s_data_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic [M_O+N_O-1:0]   m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 m_last_o,
    output logic                 err_o
);

    localparam int unsigned W_I   = exp_width(M_I, N_I);
    localparam int unsigned W_O   = exp_width(M_O, N_O);
    localparam int unsigned CNT_W = $clog2(BLK_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_LEN - 1);
    localparam logic [EXP_W-1:0] E_MAX    = EXP_W'(EXP_MAX);

    generate
        if (!params_ok(M_I, N_I, M_O, N_O, EXP_W, EXP_MAX, BLK_LEN)) begin : g_param_check
            $error("bfp_expand: illegal parameter combination");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [EXP_W-1:0] e_q;
    logic [EXP_W-1:0] raw_e;
    logic [W_O-1:0]   shifted;
    logic             s_hs;
    logic             last_beat;

    assign raw_e     = s_data_i[EXP_W-1:0];
    assign last_beat = (cnt_q == CNT_LAST);
    assign s_hs      = s_valid_i && s_ready_o;

    bfp_shift #(
        .W_I   (W_I),
        .N_I   (N_I),
        .W_O   (W_O),
        .N_O   (N_O),
        .EXP_W (EXP_W)
    ) u_shift (
        .mant (s_data_i),
        .sh   (e_q),
        .res  (shifted)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Headers are always accepted; data beats wait only on the output register.
    always_comb begin
        state_d   = state_q;
        s_ready_o = 1'b0;
        case (state_q)
            HDR: begin
                s_ready_o = 1'b1;
                if (s_valid_i) state_d = DATA;
            end
            DATA: begin
                s_ready_o = !m_valid_o || m_ready_i;
                if (s_valid_i && s_ready_o && last_beat) state_d = HDR;
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            e_q       <= '0;
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            err_o     <= 1'b0;
        end else if (state_q == HDR) begin
            if (s_hs) begin
                e_q   <= (raw_e > E_MAX) ? E_MAX : raw_e;
                cnt_q <= '0;
                if (raw_e > E_MAX) err_o <= 1'b1;
            end
            if (m_ready_i) m_valid_o <= 1'b0;
        end else if (s_hs) begin
            m_data_o  <= shifted;
            m_valid_o <= 1'b1;
            m_last_o  <= last_beat;
            cnt_q     <= last_beat ? '0 : cnt_q + CNT_W'(1);
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bfp_expand.sv
// Self-checking bench for bfp_expand: directed vectors plus randomized framing
// against a queue-based model that computes samples as mantissa * 2^e.
module tb_bfp_expand;

    localparam int unsigned M_I = 1, N_I = 15, M_O = 8, N_O = 15;
    localparam int unsigned EXP_W = 4, EXP_MAX = 7, BLK_LEN = 16;
    localparam int unsigned W_I = M_I + N_I, W_O = M_O + N_O;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [W_I-1:0] s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W_O-1:0] m_data;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic           m_last;
    logic           err;

    int n_checks = 0;
    int n_pass   = 0;

    // model state: pending output samples, data beats left in block, exponent, sticky error
    logic [W_O:0] q[$];
    int           beats_left = 0;
    int           e_m = 0;
    bit           err_m = 1'b0;
    int           outs = 0;
    bit           stall = 1'b0;

    always #5 clk = ~clk;

    bfp_expand #(
        .M_I     (M_I),
        .N_I     (N_I),
        .M_O     (M_O),
        .N_O     (N_O),
        .EXP_W   (EXP_W),
        .EXP_MAX (EXP_MAX),
        .BLK_LEN (BLK_LEN)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .s_data_i  (s_data),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_last_o  (m_last),
        .err_o     (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [W_O-1:0] expand(input logic [W_I-1:0] m, input int e);
        longint v;
        v = longint'($signed(m));
        v = v * (longint'(1) << (e + int'(N_O) - int'(N_I)));
        return W_O'(v);
    endfunction

    task automatic tick(input bit v, input logic [W_I-1:0] d, input bit rdy, output bit acc);
        bit mhs;
        bit last_pre;
        bit exp_rdy;
        logic [W_O:0] item;
        int raw;
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        m_ready = rdy;
        #1;
        exp_rdy = (beats_left == 0) || (q.size() == 0) || rdy;
        check("s_ready", 32'(s_ready), 32'(exp_rdy));
        acc      = v && s_ready;
        mhs      = m_valid && rdy;
        last_pre = m_last;
        @(posedge clk);
        #1;
        if (mhs && q.size() != 0) begin
            item = q.pop_front();
            outs++;
            check("frame_last", 32'(last_pre), 32'((outs % BLK_LEN) == 0));
        end
        if (acc) begin
            if (beats_left == 0) begin
                raw = int'(d[EXP_W-1:0]);
                e_m = (raw > int'(EXP_MAX)) ? int'(EXP_MAX) : raw;
                if (raw > int'(EXP_MAX)) err_m = 1'b1;
                beats_left = BLK_LEN;
            end else begin
                q.push_back({beats_left == 1, expand(d, e_m)});
                beats_left--;
            end
        end
        check("m_valid", 32'(m_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            item = q[0];
            check("m_data", 32'(m_data), 32'(item[W_O-1:0]));
            check("m_last", 32'(m_last), 32'(item[W_O]));
        end
        check("err", 32'(err), 32'(err_m));
    endtask

    task automatic send_beat(input logic [W_I-1:0] d);
        bit acc;
        bit v;
        bit rdy;
        acc = 1'b0;
        for (int i = 0; i < 60 && !acc; i++) begin
            v   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            tick(v, d, rdy, acc);
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_block(input logic [W_I-1:0] hdr, input logic [W_I-1:0] first,
                              input bit chk, input logic [W_O-1:0] exp_first);
        send_beat(hdr);
        send_beat(first);
        if (chk) check("directed", 32'(m_data), 32'(exp_first));
        for (int i = 1; i < int'(BLK_LEN); i++) send_beat(W_I'($urandom));
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && (q.size() != 0 || m_valid); i++) tick(1'b0, '0, 1'b1, acc);
        check("drained", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = W_I'($urandom);
        m_ready = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        beats_left = 0;
        e_m        = 0;
        err_m      = 1'b0;
        outs       = 0;
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_last", 32'(m_last), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b0;
    endtask

    initial begin
        do_reset();

        // directed value checks with a free-flowing stream
        stall = 1'b0;
        send_block(W_I'(0), 16'h4000, 1'b1, 23'h004000);
        send_block(W_I'(3), 16'h8000, 1'b1, 23'h7C0000);
        send_block(W_I'(7), 16'h7FFF, 1'b1, 23'h3FFF80);
        send_block(W_I'(12), 16'h7FFF, 1'b1, 23'h3FFF80);
        check("clamp_err", 32'(err), 32'd1);
        send_block(W_I'(0), 16'h4000, 1'b1, 23'h004000);
        check("err_sticky", 32'(err), 32'd1);
        drain();

        // three blocks under random source and sink stalls
        stall = 1'b1;
        outs  = 0;
        for (int b = 0; b < 3; b++)
            send_block(W_I'($urandom_range(0, EXP_MAX)), W_I'($urandom), 1'b0, '0);
        stall = 1'b0;
        drain();
        check("frame_count", 32'(outs), 32'd48);

        // reset in the middle of a block, then restart with exponent 2
        send_beat(W_I'(1));
        for (int i = 0; i < 5; i++) send_beat(W_I'($urandom));
        do_reset();
        send_beat(W_I'(2));
        send_beat(16'h4000);
        check("post_reset_shift", 32'(m_data), 32'h010000);
        for (int i = 1; i < int'(BLK_LEN); i++) send_beat(W_I'($urandom));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bfp_expand.md
# bfp_expand

Block-floating-point expander for the pak-dsp fixed-point datapath. It receives a stream of blocks, each a shared exponent header beat followed by `BLK_LEN` narrow Q(M_I.N_I) mantissas. It emits each mantissa as a wide Q(M_O.N_O) sample equal to mantissa × 2^E. It is the range-restoring counterpart of the saturate/truncate narrowing stage and sits at the receive side of compressed sample links.

## Interface
- `M_I`, default 1: input mantissa integer bits (including sign).
- `N_I`, default 15: input mantissa fraction bits.
- `M_O`, default 8: output integer bits; must satisfy M_O ≥ M_I + EXP_MAX.
- `N_O`, default 15: output fraction bits; must satisfy N_O ≥ N_I.
- `EXP_W`, default 4: exponent field width, taken from the header beat's `s_data_i[EXP_W-1:0]`; requires EXP_W ≤ M_I+N_I.
- `EXP_MAX`, default 7: largest legal exponent.
- `BLK_LEN`, default 16: mantissas per block; must be ≥ 1.

Ports:
- `clk_i` in 1: sole clock.
- `rst_ni` in 1: synchronous, active-low reset.
- `s_data_i` in M_I+N_I: carries the header exponent or a signed mantissa.
- `s_valid_i` in 1: input beat valid.
- `s_ready_o` out 1: input beat accepted when `s_valid_i` && `s_ready_o`.
- `m_data_o` out M_O+N_O: signed expanded sample.
- `m_valid_o` out 1: output valid.
- `m_ready_i` in 1: downstream ready.
- `m_last_o` out 1: marks the last sample of a block.
- `err_o` out 1: sticky flag; set when an out-of-range exponent is seen.

## Operation
- FSM states: HDR, DATA.
- **HDR**
  - `s_ready_o` = 1.
  - On handshake: latch e = min(`s_data_i[EXP_W-1:0]`, EXP_MAX).
  - If the raw value > EXP_MAX: set `err_o`.
  - Clear `cnt`; go to DATA.
  - No output beat is produced.
- **DATA**
  - `s_ready_o` = !`m_valid_o` || `m_ready_i` (single pipeline register, full throughput).
  - On handshake:
    - Load the output register: `m_data_o` = sign_extend(mantissa) with (N_O−N_I) zero LSBs appended, then shifted left by e.
    - Set `m_valid_o`; `m_last_o` = (`cnt` == BLK_LEN−1).
    - If `cnt` == BLK_LEN−1: `cnt` ← 0, go to HDR; else `cnt` ← `cnt`+1.
- **Output register**
  - Holds data, valid and last stable while `m_valid_o` && !`m_ready_i`.
  - Clears `m_valid_o` when `m_ready_i` is high and no new beat is loaded.
- **Arithmetic:** exact, with no rounding and no saturation. The width constraints guarantee the result fits.
- **BLK_LEN = 1:** every data beat carries `m_last_o` = 1. The FSM alternates HDR/DATA.
- **`err_o`:** stays set until reset. A clamped block still streams normally using EXP_MAX.
- **Reset values:** state HDR, `cnt` 0, e 0, `m_data_o` 0, `m_valid_o` 0, `m_last_o` 0, `err_o` 0. Reset mid-block discards the partial block and any pending output. The first accepted beat after reset is a header.

## Timing
- Latency: a data beat accepted at edge k appears on `m_*` after edge k, i.e. 1 cycle.
- Header beats cost one input cycle and create an output bubble.
- Sustained throughput is BLK_LEN outputs per BLK_LEN+1 input cycles.
- A header and the preceding block's last output may coexist: the last sample waits in the output register while the header is accepted in HDR.
- A header is never blocked by `m_ready_i`.
- `s_ready_o` is combinational from `m_ready_i` in DATA only. There is no other input-to-output combinational path.

## Structure
- `bfp_pkg`:
  - state enum (HDR, DATA);
  - helper function computing the expanded width;
  - parameter legality checks as elaboration-time assertions.
- Sub-module `bfp_shift`: purely combinational sign-extend, pad and barrel-shift (0..EXP_MAX), instantiated once.
- Top level holds the FSM, the `cnt` counter (width $clog2(BLK_LEN)+1), the exponent register and the output register.

## Test plan
- **Pass-through:** header 0, mantissa 0x4000 (0.5) -> `m_data_o` = 0x004000, 1 cycle after handshake.
- **Negative shift:** header 3, mantissa 0x8000 (−1.0) -> 0x7C0000 (−8.0).
- **Maximum magnitude:** header 7, mantissa 0x7FFF -> 0x3FFF80.
- **Clamp:** header 12, mantissa 0x7FFF -> 0x3FFF80 and `err_o` = 1, remaining high through the next block with header 0.
- **Block framing:** 3 blocks of BLK_LEN=16 with `m_ready_i` randomly low -> exactly 48 outputs, no loss or duplication, `m_last_o` on outputs 16/32/48, data stable while stalled.
- **Reset mid-block:** assert `rst_ni` low for one cycle after 5 data beats -> all outputs 0 next cycle; a following beat of value 2 is treated as a header and the next mantissa is shifted by 2.
